// File: rtl/output_serializer.sv
`default_nettype none
// ============================================================================
// output_serializer: captures a DIM x DIM matrix, streams it one element per
// valid/ready handshake. Define OUTPUT_SER_COL_MAJOR_EN for column-major order.
// Revision 1.0
// ============================================================================
module output_serializer #(
  parameter int WORD_W = 16,
  parameter int DIM    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [DIM*DIM*WORD_W-1:0]     matrix_in,
  input  logic                          word_ready,
  output logic [WORD_W-1:0]             word_out,
  output logic                          word_valid,
  output logic [$clog2(DIM)-1:0]        row_idx,
  output logic [$clog2(DIM)-1:0]        col_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int NUM_WORDS = DIM * DIM;
  localparam int MAT_W     = NUM_WORDS * WORD_W;
  localparam int IDX_W     = $clog2(DIM);
  localparam int N_W       = $clog2(NUM_WORDS);
  localparam logic [N_W-1:0] LAST_N = N_W'(NUM_WORDS - 1);
  localparam logic [N_W-1:0] DIM_N  = N_W'(DIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [MAT_W-1:0]   shadow_q, shadow_d;

  logic [IDX_W-1:0]   n_div, n_mod;
  logic [IDX_W-1:0]   row_sel, col_sel;
  logic [N_W-1:0]     k;

  assign n_div = IDX_W'(n_q / DIM_N);
  assign n_mod = IDX_W'(n_q % DIM_N);

`ifdef OUTPUT_SER_COL_MAJOR_EN
  // Column-major: consecutive words walk down a column first.
  assign row_sel = n_mod;
  assign col_sel = n_div;
  assign k       = N_W'(n_mod) * DIM_N + N_W'(n_div);
`else
  assign row_sel = n_div;
  assign col_sel = n_mod;
  assign k       = n_q;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d = matrix_in;
          n_d      = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (word_ready) begin
          if (n_q == LAST_N) begin
            state_d = DONE;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so they hold while stalled.
  always_comb begin
    word_valid = (state_q == SEND);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    word_out   = '0;
    row_idx    = '0;
    col_idx    = '0;
    if (state_q == SEND) begin
      word_out = shadow_q[k*WORD_W +: WORD_W];
      row_idx  = row_sel;
      col_idx  = col_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      shadow_q <= shadow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_serializer.sv
`default_nettype none
// ============================================================================
// tb_output_serializer: directed table, corner sequences and randomized
// transfers checked against a transaction-level model of the serializer.
// Revision 1.0
// ============================================================================
module tb_output_serializer;

  localparam int WORD_W = 16;
  localparam int DIM    = 4;
  localparam int NW     = DIM * DIM;
  localparam int MW     = NW * WORD_W;

  logic              clk = 1'b0;
  logic              reset, load, word_ready;
  logic [MW-1:0]     matrix_in;
  logic [WORD_W-1:0] word_out;
  logic              word_valid, busy, done;
  logic [1:0]        row_idx, col_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_serializer #(.WORD_W(WORD_W), .DIM(DIM)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .matrix_in  (matrix_in),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .busy       (busy),
    .done       (done)
  );

  // Sequence position n -> matrix element index k.
  function automatic int k_of(input int n);
`ifdef OUTPUT_SER_COL_MAJOR_EN
    return (n % DIM) * DIM + n / DIM;
`else
    return n;
`endif
  endfunction

  function automatic int row_of(input int n);
    return k_of(n) / DIM;
  endfunction

  function automatic int col_of(input int n);
    return k_of(n) % DIM;
  endfunction

  // Packed status: {valid, busy, done, row[1:0], col[1:0], word[15:0]}.
  function automatic logic [31:0] st(input int v, input int b, input int d,
                                     input int r, input int c, input int w);
    return {9'd0, v[0], b[0], d[0], r[1:0], c[1:0], w[15:0]};
  endfunction

  function automatic logic [31:0] act_st();
    return {9'd0, word_valid, busy, done, row_idx, col_idx, word_out};
  endfunction

  function automatic logic [MW-1:0] mk(input int base);
    logic [MW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WORD_W +: WORD_W] = WORD_W'(base + i);
    return r;
  endfunction

  function automatic logic [MW-1:0] mk_rand();
    logic [MW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transfer from IDLE. Model: the captured matrix is frozen and the n-th
  // accepted word is element k_of(n); done follows the 16th accept by one cycle.
  task automatic xfer(input logic [MW-1:0] m, input int stall_pct,
                      input int stall_n, input int stall_len,
                      input int poke_n, input int reset_n);
    logic [MW-1:0] cap;
    int  n;
    int  stalls;
    bit  rst_pend;
    cap = m; n = 0; stalls = 0; rst_pend = 1'b0;
    matrix_in  = m;
    load       = 1'b1;
    word_ready = 1'($urandom);
    @(negedge clk);
    load = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (rst_pend) begin
        reset = 1'b0;
        chk("abort_state", act_st(), st(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("abort_no_done", act_st(), st(0, 0, 0, 0, 0, 0));
        return;
      end
      if (n == NW) begin
        chk("done_pulse", act_st(), st(0, 1, 1, 0, 0, 0));
        word_ready = 1'($urandom);
        @(negedge clk);
        chk("idle_after_done", act_st(), st(0, 0, 0, 0, 0, 0));
        return;
      end
      chk("stream_word", act_st(),
          st(1, 1, 0, row_of(n), col_of(n), int'(cap[k_of(n)*WORD_W +: WORD_W])));
      word_ready = 1'b1;
      if (n == stall_n && stalls < stall_len) begin
        word_ready = 1'b0;
        stalls++;
      end else if ($urandom_range(99) < stall_pct) begin
        word_ready = 1'b0;
      end
      if (n == poke_n) begin
        load      = 1'b1;
        matrix_in = '1;
      end else begin
        load = 1'b0;
      end
      if (n == reset_n) begin
        reset    = 1'b1;
        rst_pend = 1'b1;
      end
      if (word_ready && !rst_pend) n++;
      @(negedge clk);
    end
    chk("xfer_timeout", n, NW);
  endtask

  typedef struct {
    logic        ld;
    logic        rdy;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0] = '{1'b1, 1'b1, st(1, 1, 0, row_of(0), col_of(0), 32'h0100 + k_of(0))};
    for (int i = 1; i < NW; i++)
      tbl[i] = '{1'b0, 1'b1, st(1, 1, 0, row_of(i), col_of(i), 32'h0100 + k_of(i))};
    tbl[16] = '{1'b0, 1'b1, st(0, 1, 1, 0, 0, 0)};
    tbl[17] = '{1'b0, 1'b1, st(0, 0, 0, 0, 0, 0)};

    // Reset overrides a simultaneous load.
    reset      = 1'b1;
    load       = 1'b1;
    word_ready = 1'b1;
    matrix_in  = mk(16'h0100);
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", act_st(), st(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    chk("idle_no_load", act_st(), st(0, 0, 0, 0, 0, 0));

    // Back-to-back stream with ready held high: 16 words, done on cycle 17.
    for (int i = 0; i < 18; i++) begin
      load       = tbl[i].ld;
      word_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("table_%0d", i), act_st(), tbl[i].exp);
    end

    xfer(mk(16'h0100), 0, 5, 3, -1, -1);   // stall 3 cycles at n=5
    xfer(mk(16'h0100), 0, -1, 0, 8, -1);   // reload + matrix change mid-stream
    xfer(mk(16'h0100), 0, -1, 0, -1, 10);  // reset at n=10
    xfer(mk(16'h0100), 0, -1, 0, -1, -1);  // restart after abort

    for (int t = 0; t < 25; t++) begin
      int poke;
      int rst_n;
      poke  = ($urandom_range(1)    == 1) ? int'($urandom_range(NW - 1)) : -1;
      rst_n = ($urandom_range(4)    == 0) ? int'($urandom_range(NW - 1)) : -1;
      xfer(mk_rand(), 35, int'($urandom_range(NW - 1)), int'($urandom_range(4)),
           poke, rst_n);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 SHALL provide parameter WORD_W, default 16, bit width of one matrix element.
REQ-002 SHALL provide parameter DIM, default 4, matrix rows and columns; matrix width is DIM*DIM*WORD_W (256 at defaults).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, request to capture matrix_in and start streaming.
REQ-006 SHALL have port matrix_in, input, DIM*DIM*WORD_W, matrix from the output register; element k = row*DIM+col occupies bits [k*WORD_W+WORD_W-1 : k*WORD_W].
REQ-007 SHALL have port word_ready, input, 1, downstream able to accept word_out this cycle.
REQ-008 SHALL have port word_out, output, WORD_W, current element being offered.
REQ-009 SHALL have port word_valid, output, 1, word_out is valid.
REQ-010 SHALL have port row_idx and col_idx, output, $clog2(DIM) each, matrix position of word_out.
REQ-011 SHALL have port busy, output, 1, high from capture until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last word is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, DONE.
REQ-014 IDLE: load=1 at an edge SHALL capture matrix_in into an internal shadow register, clear the sequence counter n to 0, and enter SEND; word_valid is high on the following cycle (1-cycle latency).
REQ-015 SEND: word_valid SHALL be 1; a handshake occurs on an edge with word_valid && word_ready.
REQ-016 On a handshake with n < DIM*DIM-1, n SHALL increment by 1; with n = DIM*DIM-1, FSM SHALL enter DONE.
REQ-017 While word_valid && !word_ready, word_out, row_idx and col_idx SHALL hold stable.
REQ-018 Default order SHALL be row-major: sequence n maps to element k = n, row_idx = n / DIM, col_idx = n % DIM.
REQ-019 DONE: done=1, word_valid=0, busy=1 for exactly one cycle, then IDLE.
REQ-020 load SHALL be ignored in SEND and DONE; the shadow register SHALL NOT change until the next IDLE capture.
REQ-021 With word_ready held high, load-to-done SHALL be 17 cycles at defaults: 16 words on 16 consecutive cycles, done on the next cycle.
REQ-022 In IDLE, word_valid, busy and done SHALL be 0 and word_out SHALL be 0.
REQ-023 Changes on matrix_in after capture SHALL NOT affect the words streamed.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, n=0, shadow register=0, and all outputs to 0, overriding load and any handshake in the same cycle.
REQ-025 Reset mid-stream SHALL abort the transfer with no done pulse; word_valid is 0 from the next cycle.

Configuration
REQ-026 Macro OUTPUT_SER_COL_MAJOR_EN: when defined, sequence n SHALL map to element k = (n % DIM)*DIM + n / DIM, with row_idx = n % DIM and col_idx = n / DIM (column-major). When undefined, row-major per REQ-018 applies. All other timing is identical in both builds.

Verification
REQ-027 Reset, then load with matrix_in element k = 16'h0100+k and word_ready=1 -> words 0x0100..0x010F on 16 consecutive cycles, done pulses on cycle 17 after load, busy low on cycle 18.
REQ-028 Same stimulus, word_ready low for 3 cycles at n=5 -> word_out holds 0x0105 with row_idx=1, col_idx=1 for 4 cycles; no word is skipped or duplicated.
REQ-029 Pulse load again at n=8, and change matrix_in to all-ones mid-stream -> stream continues unchanged, exactly 16 words, a single done pulse.
REQ-030 Assert reset at n=10 -> word_valid=0, busy=0 next cycle, no done pulse; a new load then restarts from n=0.
REQ-031 Build with OUTPUT_SER_COL_MAJOR_EN using the stimulus of REQ-027 -> sequence 0x0100,0x0104,0x0108,0x010C,0x0101,... ending 0x010F.
